fp_div_seq: RTL and testbench

- Iterative IEEE-754 single-precision divider, z = a / b, the inverse operation to the existing pipelined multiplier.
- Uses the same rounding-mode enum and 8-bit status format as the multiplier, so both units can share one result path and checker.
- Operands enter through a valid/ready handshake and results leave through one; the unit is non-pipelined, one division in flight.
- Mantissa quotient comes from a restoring shift-subtract loop followed by one rounding cycle.

---
 rtl/fp_div_pkg.sv | 33 +++
 rtl/round_pkg.sv | 13 +
 rtl/fp_div_round.sv | 86 ++++++++
 rtl/fp_div_seq.sv | 178 +++++++++++++++++
 tb/tb_fp_div_seq.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_div_pkg.sv
// Constants, status layout and FSM encoding for the sequential single-precision divider.
// FP_DIV_RADIX4_EN selects two restoring steps per DIV cycle.
package fp_div_pkg;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;
  localparam int ST_DBZ     = 6;

  localparam logic [31:0] QNAN_C    = 32'h7FC0_0000;
  localparam logic [31:0] MAXNORM_C = 32'h7F7F_FFFF;
  localparam logic [31:0] MINNORM_C = 32'h0080_0000;

  // 24 mantissa bits + normalization bit + guard bit
  localparam int QBITS = 26;
`ifdef FP_DIV_RADIX4_EN
  localparam int RADIX_BITS = 2;
`else
  localparam int RADIX_BITS = 1;
`endif
  localparam int DIV_CYCLES = QBITS / RADIX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/round_pkg.sv
// Shared rounding-mode encoding for the floating-point multiplier and divider.
package round_pkg;

  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } round_mode;

endpackage

// File: rtl/fp_div_round.sv
// Combinational rounding, overflow and underflow handling for a normalized quotient.
module fp_div_round
  import fp_div_pkg::*;
  import round_pkg::*;
(
  input  logic        sign,
  input  logic [9:0]  e,
  input  logic [22:0] mant,
  input  logic        guard,
  input  logic        sticky,
  input  round_mode   mode,
  output logic [31:0] z,
  output logic [7:0]  status
);

  logic        inexact;
  logic        inc;
  logic        ovf_to_inf;
  logic        unf_to_min;
  logic [23:0] mant_sum;
  logic [9:0]  e_rnd;
  logic        ovf;
  logic        unf;

  always_comb begin
    inexact = guard | sticky;
    inc        = 1'b0;
    ovf_to_inf = 1'b0;
    unf_to_min = 1'b0;
    case (mode)
      IEEE_near: begin
        inc        = guard & (sticky | mant[0]);
        ovf_to_inf = 1'b1;
      end
      near_up: begin
        inc        = guard;
        ovf_to_inf = 1'b1;
      end
      away_zero: begin
        inc        = inexact;
        ovf_to_inf = 1'b1;
        unf_to_min = 1'b1;
      end
      IEEE_pinf: begin
        inc        = ~sign & inexact;
        ovf_to_inf = ~sign;
        unf_to_min = ~sign;
      end
      IEEE_ninf: begin
        inc        = sign & inexact;
        ovf_to_inf = sign;
        unf_to_min = sign;
      end
      default: begin
        inc = 1'b0;
      end
    endcase
  end

  // Carry out of the 23-bit fraction means the significand became 2.0
  assign mant_sum = {1'b0, mant} + {23'd0, inc};
  assign e_rnd    = e + {9'd0, mant_sum[23]};
  assign ovf      = $signed(e_rnd) >= 10'sd255;
  assign unf      = $signed(e_rnd) <= 10'sd0;

  always_comb begin
    status              = '0;
    z                   = {sign, e_rnd[7:0], mant_sum[22:0]};
    status[ST_INEXACT]  = inexact;
    if (ovf) begin
      status[ST_HUGE]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      z = ovf_to_inf ? {sign, 8'hFF, 23'd0} : {sign, MAXNORM_C[30:0]};
    end else if (unf) begin
      status[ST_TINY]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      if (unf_to_min) begin
        z = {sign, MINNORM_C[30:0]};
      end else begin
        z               = {sign, 31'd0};
        status[ST_ZERO] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE single-precision divider z = a / b using restoring shift-subtract.
// Build option FP_DIV_RADIX4_EN retires two quotient bits per DIV cycle.
module fp_div_seq
  import fp_div_pkg::*;
  import round_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rnd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic [7:0]  status
);

  state_t      state_reg;
  state_t      state_next;
  logic [4:0]  cnt_reg;
  logic [24:0] rem_reg;
  logic [23:0] dvs_reg;
  logic [25:0] q_reg;
  logic        sign_reg;
  logic [9:0]  exp_reg;
  round_mode   mode_reg;
  logic [31:0] z_reg;
  logic [7:0]  status_reg;

  // Operand classification on the input bus, used only at acceptance
  logic        a_zero, b_zero, a_max, b_max, a_nan, b_nan, a_inf, b_inf;
  logic        special;
  logic        res_sign;
  logic [31:0] spec_z;
  logic [7:0]  spec_status;
  logic [9:0]  exp_calc;

  assign a_zero   = (a[30:23] == 8'd0);
  assign b_zero   = (b[30:23] == 8'd0);
  assign a_max    = (a[30:23] == 8'hFF);
  assign b_max    = (b[30:23] == 8'hFF);
  assign a_nan    = a_max & (|a[22:0]);
  assign b_nan    = b_max & (|b[22:0]);
  assign a_inf    = a_max & ~(|a[22:0]);
  assign b_inf    = b_max & ~(|b[22:0]);
  assign special  = a_zero | b_zero | a_max | b_max;
  assign res_sign = a[31] ^ b[31];
  assign exp_calc = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;

  always_comb begin
    spec_z      = {res_sign, 31'd0};
    spec_status = '0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_z              = QNAN_C;
      spec_status[ST_NAN] = 1'b1;
    end else if (b_zero & ~a_inf) begin
      spec_z              = {res_sign, 8'hFF, 23'd0};
      spec_status[ST_INF] = 1'b1;
      spec_status[ST_DBZ] = 1'b1;
    end else if (a_inf) begin
      spec_z              = {res_sign, 8'hFF, 23'd0};
      spec_status[ST_INF] = 1'b1;
    end else begin
      spec_status[ST_ZERO] = 1'b1;
    end
  end

  // Chained restoring steps; stage 0 yields the more significant quotient bit
  logic [24:0]           rem_chain [RADIX_BITS+1];
  logic [RADIX_BITS-1:0] q_step;

  assign rem_chain[0] = rem_reg;

  for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_step
    logic        ge;
    logic [23:0] diff;
    assign ge   = rem_chain[gi] >= {1'b0, dvs_reg};
    assign diff = rem_chain[gi][23:0] - dvs_reg;
    assign q_step[RADIX_BITS-1-gi] = ge;
    assign rem_chain[gi+1] = {(ge ? diff : rem_chain[gi][23:0]), 1'b0};
  end

  // Normalization of the finished quotient ahead of rounding
  logic        norm;
  logic [22:0] rnd_mant;
  logic        rnd_guard;
  logic        rnd_sticky;
  logic [9:0]  rnd_exp;
  logic [31:0] rnd_z;
  logic [7:0]  rnd_status;

  assign norm       = q_reg[25];
  assign rnd_mant   = norm ? q_reg[24:2] : q_reg[23:1];
  assign rnd_guard  = norm ? q_reg[1] : q_reg[0];
  assign rnd_sticky = (rem_reg != 25'd0) | (norm & q_reg[0]);
  assign rnd_exp    = norm ? exp_reg : exp_reg - 10'd1;

  fp_div_round u_round (
    .sign   (sign_reg),
    .e      (rnd_exp),
    .mant   (rnd_mant),
    .guard  (rnd_guard),
    .sticky (rnd_sticky),
    .mode   (mode_reg),
    .z      (rnd_z),
    .status (rnd_status)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = special ? DONE : DIV;
      DIV:     if (cnt_reg == 5'(DIV_CYCLES - 1)) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      q_reg      <= '0;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mode_reg   <= IEEE_near;
      z_reg      <= '0;
      status_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg <= res_sign;
            exp_reg  <= exp_calc;
            rem_reg  <= {2'b01, a[22:0]};
            dvs_reg  <= {1'b1, b[22:0]};
            q_reg    <= '0;
            cnt_reg  <= '0;
            mode_reg <= round_mode'(rnd);
            if (special) begin
              z_reg      <= spec_z;
              status_reg <= spec_status;
            end
          end
        end
        DIV: begin
          rem_reg <= rem_chain[RADIX_BITS];
          q_reg   <= {q_reg[QBITS-RADIX_BITS-1:0], q_step};
          cnt_reg <= cnt_reg + 5'd1;
        end
        ROUND: begin
          z_reg      <= rnd_z;
          status_reg <= rnd_status;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign z         = z_reg;
  assign status    = status_reg;

endmodule

// File: tb/tb_fp_div_seq.sv
// Randomized and directed bench for fp_div_seq with an integer-arithmetic reference model.
module tb_fp_div_seq;
  import round_pkg::*;

`ifdef FP_DIV_RADIX4_EN
  localparam int NORM_LAT = 15;
`else
  localparam int NORM_LAT = 28;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  rnd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] z;
  logic [7:0]  status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .status    (status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient of the significands, then the rounding rules
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                                  output logic [31:0] rz, output logic [7:0] rs, output bit spec);
    int ex, ey, e;
    bit s, xz, yz, xi, yi, xn, yn, g, st, inexact, away_dir, inc;
    longint unsigned num, den, q, r, sig;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    spec = 1'b1;
    rs = 8'h00;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      rz = 32'h7FC00000; rs = 8'h04; return;
    end
    if (yz && !xi) begin rz = {s, 31'h7F800000}; rs = 8'h42; return; end
    if (xi) begin rz = {s, 31'h7F800000}; rs = 8'h02; return; end
    if (yi || xz) begin rz = {s, 31'd0}; rs = 8'h01; return; end
    spec = 1'b0;
    num = {40'd1, x[22:0]};
    num = num << 25;
    den = {40'd1, y[22:0]};
    q = num / den;
    r = num % den;
    e = ex - ey + 127;
    if (q >= (64'd1 << 25)) begin
      sig = q >> 2; g = q[1]; st = q[0] || (r != 0);
    end else begin
      sig = q >> 1; g = q[0]; st = (r != 0); e = e - 1;
    end
    inexact  = g || st;
    away_dir = (m == away_zero) || (m == IEEE_pinf && !s) || (m == IEEE_ninf && s);
    if (m == IEEE_near)    inc = g && (st || sig[0]);
    else if (m == near_up) inc = g;
    else                   inc = away_dir && inexact;
    sig = sig + (inc ? 64'd1 : 64'd0);
    if (sig == (64'd1 << 24)) begin sig = 64'd1 << 23; e = e + 1; end
    if (e >= 255) begin
      rs = 8'h30;
      rz = (away_dir || m == IEEE_near || m == near_up) ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
    end else if (e <= 0) begin
      rs = 8'h28;
      if (away_dir) rz = {s, 31'h00800000};
      else begin rz = {s, 31'd0}; rs = 8'h29; end
    end else begin
      rz = {s, e[7:0], sig[22:0]};
      rs = inexact ? 8'h20 : 8'h00;
    end
  endfunction

  // One transaction from IDLE; hold = cycles of out_ready=0 with in_valid noise in DONE
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m, input int hold,
                        output logic [31:0] oz, output logic [7:0] os, output int lat);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = x; b = y; rnd = m; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; rnd = 3'($urandom_range(0, 5));
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    oz = z;
    os = status;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      check("hold_z", z, oz);
      check("hold_status", 32'(status), 32'(os));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_handshake_out_valid", 32'(out_valid), 32'd0);
    $display("op a=%h b=%h rnd=%0d z=%h status=%h lat=%0d", x, y, m, oz, os, lat);
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                          input int hold, input logic [31:0] ez, input logic [7:0] es, input int elat);
    logic [31:0] oz;
    logic [7:0]  os;
    int          lat;
    run_op(x, y, m, hold, oz, os, lat);
    check({tag, "_z"}, oz, ez);
    check({tag, "_status"}, 32'(os), 32'(es));
    check({tag, "_latency"}, 32'(lat), 32'(elat));
  endtask

  function automatic logic [31:0] rand_operand(input int kind);
    logic [31:0] r;
    logic [7:0]  e;
    int          sel;
    r = $urandom;
    e = 8'($urandom_range(1, 254));
    if (kind == 0) e = 8'($urandom_range(110, 144));
    if (kind == 2) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: e = 8'h00;
        1: begin e = 8'hFF; r[22:0] = 23'd0; end
        2: begin e = 8'hFF; r[0] = 1'b1; end
        default: begin end
      endcase
    end
    r[30:23] = e;
    return r;
  endfunction

  initial begin
    logic [31:0] oz, ez, x, y;
    logic [7:0]  os, es;
    logic [2:0]  m;
    int          lat, kind, hold;
    bit          spec, seen;

    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_z", z, 32'd0);
    check("reset_status", 32'(status), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    directed("six_by_two", 32'h40C00000, 32'h40000000, IEEE_near, 0, 32'h40400000, 8'h00, NORM_LAT);
    directed("third_near", 32'h3F800000, 32'h40400000, IEEE_near, 0, 32'h3EAAAAAB, 8'h20, NORM_LAT);
    directed("third_zero", 32'h3F800000, 32'h40400000, IEEE_zero, 0, 32'h3EAAAAAA, 8'h20, NORM_LAT);
    directed("div_by_zero", 32'h3F800000, 32'h00000000, IEEE_near, 0, 32'h7F800000, 8'h42, 1);
    directed("zero_by_zero", 32'h00000000, 32'h00000000, IEEE_near, 0, 32'h7FC00000, 8'h04, 1);
    directed("ovf_near", 32'h7F000000, 32'h3E800000, IEEE_near, 0, 32'h7F800000, 8'h30, NORM_LAT);
    directed("ovf_zero", 32'h7F000000, 32'h3E800000, IEEE_zero, 0, 32'h7F7FFFFF, 8'h30, NORM_LAT);
    directed("unf_near", 32'h00800000, 32'h40000000, IEEE_near, 0, 32'h00000000, 8'h29, NORM_LAT);
    directed("unf_away", 32'h00800000, 32'h40000000, away_zero, 0, 32'h00800000, 8'h28, NORM_LAT);
    directed("backpressure", 32'h3F800000, 32'h40400000, IEEE_near, 5, 32'h3EAAAAAB, 8'h20, NORM_LAT);

    // Abort a division with reset, then confirm no stale result appears
    a = 32'h40C00000; b = 32'h40000000; rnd = IEEE_near; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_z", z, 32'd0);
    check("abort_status", 32'(status), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    directed("after_reset", 32'h40C00000, 32'h40000000, IEEE_near, 0, 32'h40400000, 8'h00, NORM_LAT);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 5) ? 0 : ((kind < 8) ? 1 : 2);
      x = rand_operand(kind);
      y = rand_operand(kind);
      m = 3'($urandom_range(0, 5));
      hold = $urandom_range(0, 2);
      ref_div(x, y, m, ez, es, spec);
      run_op(x, y, m, hold, oz, os, lat);
      check("rand_z", oz, ez);
      check("rand_status", 32'(os), 32'(es));
      check("rand_latency", 32'(lat), spec ? 32'd1 : 32'(NORM_LAT));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
